// File: rtl/smu_cfg_loader_pkg.sv
// Shared types and constants for the SMU configuration loader.
package smu_pkg;

  localparam logic [31:0] DEFAULT_DECRYPT_KEY = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } smu_ldr_state_e;

  // Number of stream words needed to cover the whole cfg image.
  function automatic int unsigned cfg_words(input int unsigned cfgSize, input int unsigned wordW);
    return (cfgSize + wordW - 1) / wordW;
  endfunction

endpackage

// File: rtl/smu_cfg_loader_if.sv
// Word-serial valid/ready stream carrying the encrypted cfg image.
interface smu_cfg_loader_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic [WORD_W-1:0] InWord;
  logic              InValid;
  logic              InReady;

  modport master (output InWord, output InValid, input InReady);
  modport slave  (input InWord, input InValid, output InReady);
endinterface

// File: rtl/smu_cfg_word_decrypt.sv
// XOR decryption of a stream word plus the running checksum of decrypted data words.
module smu_cfg_word_decrypt
  import smu_pkg::*;
#(
  parameter int unsigned       WORD_W = 32,
  parameter logic [WORD_W-1:0] KEY    = WORD_W'(DEFAULT_DECRYPT_KEY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accumulate,
  input  logic [WORD_W-1:0] encWord,
  output logic [WORD_W-1:0] decWord,
  output logic [WORD_W-1:0] csum
);

  assign decWord = encWord ^ KEY;

  // A restart wins over a coincident data word, which is discarded.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      csum <= '0;
    end else if (accumulate) begin
      csum <= csum ^ decWord;
    end
  end

endmodule

// File: rtl/smu_cfg_loader.sv
// Loads, verifies and commits the SMU cfg image, and gates SmuEn on a verified image.
module smu_cfg_loader
  import smu_pkg::*;
#(
  parameter int unsigned       CFG_SIZE    = 512,
  parameter int unsigned       WORD_W      = 32,
  parameter logic [WORD_W-1:0] DECRYPT_KEY = WORD_W'(DEFAULT_DECRYPT_KEY),
  parameter int unsigned       TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Start,
  smu_cfg_loader_if.slave     cfgBus,
  input  logic                GlobalSmuEn,
  output logic [CFG_SIZE-1:0] CfgOut,
  output logic                BitstreamLoaded,
  output logic                SmuEn,
  output logic                LoadError,
  output logic                Busy
);

  localparam int unsigned NWORDS = cfg_words(CFG_SIZE, WORD_W);
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned PAD_W  = NWORDS * WORD_W;

  smu_ldr_state_e    state;
  logic [CNT_W-1:0]  wordCnt;
  logic [IDLE_W-1:0] idleCnt;
  logic [PAD_W-1:0]  shadow;
  logic [WORD_W-1:0] decWord;
  logic [WORD_W-1:0] csum;
  logic              active;
  logic              xfer;
  logic              idleExpired;

  assign active          = (state == ST_LOAD) || (state == ST_CHECK);
  assign cfgBus.InReady  = active;
  assign Busy            = active;
  assign BitstreamLoaded = (state == ST_DONE);
  assign LoadError       = (state == ST_ERR);
  assign xfer            = cfgBus.InValid && active;
  assign idleExpired     = (idleCnt == IDLE_W'(TIMEOUT - 1));

  smu_cfg_word_decrypt #(
    .WORD_W (WORD_W),
    .KEY    (DECRYPT_KEY)
  ) uDecrypt (
    .clk        (clk),
    .rst        (rst),
    .clear      (Start),
    .accumulate (xfer && (state == ST_LOAD)),
    .encWord    (cfgBus.InWord),
    .decWord    (decWord),
    .csum       (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wordCnt <= '0;
      idleCnt <= '0;
      shadow  <= '0;
      CfgOut  <= '0;
      SmuEn   <= 1'b0;
    end else begin
      // Start also masks SmuEn so the trigger units stop as soon as a reload is requested.
      SmuEn <= GlobalSmuEn && (state == ST_DONE) && !Start;
      if (Start) begin
        state   <= ST_LOAD;
        wordCnt <= '0;
        idleCnt <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (xfer) begin
              shadow[wordCnt*WORD_W +: WORD_W] <= decWord;
              idleCnt <= '0;
              if (wordCnt == CNT_W'(NWORDS - 1)) begin
                state <= ST_CHECK;
              end else begin
                wordCnt <= wordCnt + 1'b1;
              end
            end else if (idleExpired) begin
              state <= ST_ERR;
            end else begin
              idleCnt <= idleCnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (xfer) begin
              idleCnt <= '0;
              if (decWord == csum) begin
                CfgOut <= shadow[CFG_SIZE-1:0];
                state  <= ST_DONE;
              end else begin
                state <= ST_ERR;
              end
            end else if (idleExpired) begin
              state <= ST_ERR;
            end else begin
              idleCnt <= idleCnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
